// File: rtl/transpose_engine.sv
// Element-serial matrix transpose engine with start/busy/done handshake.
// Inputs are latched on acceptance and the result is held until the next accepted start.
module transpose_engine #(
  parameter int unsigned MAX_DIM = 5,
  parameter int unsigned ELEM_W  = 8,
  parameter int unsigned DIM_W   = $clog2(MAX_DIM + 1)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [DIM_W-1:0]                    m_in,
  input  logic [DIM_W-1:0]                    n_in,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_in,
  output logic                                busy,
  output logic                                done,
  output logic                                valid,
  output logic                                error,
  output logic [DIM_W-1:0]                    m_out,
  output logic [DIM_W-1:0]                    n_out,
  output logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   matrix_out
);

  localparam int unsigned MAT_W = MAX_DIM * MAX_DIM * ELEM_W;
  localparam int unsigned IDX_W = $clog2(MAT_W);

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    FIN,
    ERR
  } state_t;

  state_t             state, state_d;
  logic [DIM_W-1:0]   m_lat, m_lat_d;
  logic [DIM_W-1:0]   n_lat, n_lat_d;
  logic [MAT_W-1:0]   mat_lat, mat_lat_d;
  logic [DIM_W-1:0]   r, r_d;
  logic [DIM_W-1:0]   c, c_d;

  logic               busy_d, done_d, valid_d, error_d;
  logic [DIM_W-1:0]   m_out_d, n_out_d;
  logic [MAT_W-1:0]   mat_out_d;

  logic               dims_ok_c;
  logic               c_last_c;
  logic               r_last_c;
  logic [IDX_W-1:0]   src_base_c;
  logic [IDX_W-1:0]   dst_base_c;

  // Request legality and copy-loop position decode
  always_comb begin
    dims_ok_c  = (m_in != '0) && (m_in <= DIM_W'(MAX_DIM)) &&
                 (n_in != '0) && (n_in <= DIM_W'(MAX_DIM));
    c_last_c   = (c == n_lat - DIM_W'(1));
    r_last_c   = (r == m_lat - DIM_W'(1));
    src_base_c = IDX_W'((IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c)) * IDX_W'(ELEM_W));
    dst_base_c = IDX_W'((IDX_W'(c) * IDX_W'(MAX_DIM) + IDX_W'(r)) * IDX_W'(ELEM_W));
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    m_lat_d   = m_lat;
    n_lat_d   = n_lat;
    mat_lat_d = mat_lat;
    r_d       = r;
    c_d       = c;
    busy_d    = busy;
    done_d    = 1'b0;
    valid_d   = valid;
    error_d   = error;
    m_out_d   = m_out;
    n_out_d   = n_out;
    mat_out_d = matrix_out;

    case (state)
      IDLE: begin
        if (start) begin
          m_lat_d   = m_in;
          n_lat_d   = n_in;
          mat_lat_d = matrix_in;
          mat_out_d = '0;
          valid_d   = 1'b0;
          error_d   = 1'b0;
          m_out_d   = '0;
          n_out_d   = '0;
          r_d       = '0;
          c_d       = '0;
          if (dims_ok_c) begin
            busy_d  = 1'b1;
            state_d = COPY;
          end else begin
            state_d = ERR;
          end
        end
      end

      COPY: begin
        // Source (r,c) lands at destination (c,r); traversal is row-major over the source
        mat_out_d[dst_base_c +: ELEM_W] = mat_lat[src_base_c +: ELEM_W];
        if (c_last_c) begin
          c_d = '0;
          r_d = r + DIM_W'(1);
          if (r_last_c) begin
            state_d = FIN;
          end
        end else begin
          c_d = c + DIM_W'(1);
        end
      end

      FIN: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        m_out_d = n_lat;
        n_out_d = m_lat;
        state_d = IDLE;
      end

      ERR: begin
        done_d    = 1'b1;
        error_d   = 1'b1;
        valid_d   = 1'b0;
        busy_d    = 1'b0;
        m_out_d   = '0;
        n_out_d   = '0;
        mat_out_d = '0;
        state_d   = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      m_lat      <= '0;
      n_lat      <= '0;
      mat_lat    <= '0;
      r          <= '0;
      c          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      error      <= 1'b0;
      m_out      <= '0;
      n_out      <= '0;
      matrix_out <= '0;
    end else begin
      state      <= state_d;
      m_lat      <= m_lat_d;
      n_lat      <= n_lat_d;
      mat_lat    <= mat_lat_d;
      r          <= r_d;
      c          <= c_d;
      busy       <= busy_d;
      done       <= done_d;
      valid      <= valid_d;
      error      <= error_d;
      m_out      <= m_out_d;
      n_out      <= n_out_d;
      matrix_out <= mat_out_d;
    end
  end

endmodule

// File: doc/transpose_engine.md
# transpose_engine

Parametrised, sequential matrix-transpose engine for the matrix-calculator datapath. It generalises the combinational transpose unit in four ways: configurable maximum dimension and element width, a start/busy/done handshake, an element-serial copy FSM, and explicit dimension-error reporting. It sits between the operand-selection stage and the result display/storage stage. The result is held stable until the next accepted start.

## Interface
- MAX_DIM, 5: maximum rows/columns; packed row stride is MAX_DIM elements.
- ELEM_W, 8: element width in bits.
- DIM_W, $clog2(MAX_DIM+1): width of dimension ports (3 for defaults).
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state and outputs.
- start  in  1  request; accepted only when busy=0.
- m_in  in  DIM_W  source row count.
- n_in  in  DIM_W  source column count.
- matrix_in  in  MAX_DIM*MAX_DIM*ELEM_W  source matrix; element (r,c) at bits [(r*MAX_DIM+c)*ELEM_W +: ELEM_W].
- busy  out  1  copy in progress.
- done  out  1  one-cycle completion pulse (success or error).
- valid  out  1  result valid; held until the next accepted start or reset.
- error  out  1  last request had illegal dimensions; held like valid.
- m_out  out  DIM_W  result rows (= n_in of the accepted request).
- n_out  out  DIM_W  result columns (= m_in of the accepted request).
- matrix_out  out  MAX_DIM*MAX_DIM*ELEM_W  result matrix, same packing as matrix_in.

## Operation
- States: IDLE, COPY, FIN, ERR.
- IDLE, start=1: latch m_in, n_in and matrix_in; clear matrix_out, valid, error, m_out and n_out.
  - Dimensions are legal iff 1 <= m_in <= MAX_DIM and 1 <= n_in <= MAX_DIM.
  - Legal: go to COPY with busy=1 and r=c=0.
  - Illegal: go to ERR.
- COPY: each cycle, write latched element (r,c) to output position (c,r).
  - Index order is row-major over the source: c increments; when c=m_lat... c wraps at n_lat-1 to 0 and r increments.
  - On the element (m_lat-1, n_lat-1), go to FIN.
- FIN: done=1, valid=1, busy=0, m_out=n_lat, n_out=m_lat; return to IDLE.
- ERR: done=1, error=1, valid=0, busy=0, m_out=n_out=0, matrix_out all zero; return to IDLE.
- start is ignored while busy=1. Input changes after acceptance do not affect the result, because all inputs are latched.
- Output positions outside the m_out x n_out region are always zero after acceptance.
- Loop counters are DIM_W bits wide. No arithmetic is performed on element data; elements are moved bit-exact.

## Timing
- Reset values: busy=0, done=0, valid=0, error=0, m_out=0, n_out=0, matrix_out=0, state IDLE.
- Call the accepting edge E0.
  - Legal request: busy=1 after E0. The element writes occur at edges E1..E(m*n). busy=0 and done=1 become visible after edge E(m*n+1). done drops after the following edge.
  - Latency from start to done is therefore m*n+1 edges; for a 5x5 matrix this is 26.
  - Illegal request: done=1 and error=1 are visible after E1.
- start asserted in the same cycle that done is high is accepted, because the state is IDLE-bound and busy=0 in that cycle. The new request clears valid on its accepting edge.
- Reset takes priority over everything. Reset asserted mid-COPY aborts the operation: the next cycle shows all reset values, and no done pulse is produced.
- A start held high continuously re-triggers once each time the engine is in IDLE.

## Test plan
- 1x3 input [1 2 3]: busy for 3 copy edges, then done pulse -> valid=1, m_out=3, n_out=1, matrix_out elements (0,0)=1, (1,0)=2, (2,0)=3, all other bits 0.
- 5x5 input with (r,c)=10r+c: done after 26 edges -> every output (c,r)=10r+c, m_out=n_out=5.
- m_in=0, n_in=2, and separately m_in=6, n_in=1: done after 1 edge -> error=1, valid=0, matrix_out=0.
- 2x4 transfer with start pulsed again and matrix_in changed mid-COPY: restart ignored -> result is the 4x2 transpose of the originally latched data.
- reset asserted at the 3rd COPY cycle of a 3x3 transfer: all outputs 0 next cycle, no done pulse. A subsequent 2x2 request [1 2; 3 4] then yields [1 3; 2 4].
- Back-to-back: start held high through a 2x3 then a 3x2 request -> two done pulses, with valid cleared between them. Final m_out=2, n_out=3.
